// File: rtl/dsp_add8_cin_tb_pkg.sv
// rtl/dsp_add8_cin_tb_pkg.sv - shared types, directed vectors and golden-sum helpers for the adder stimulus generator
package dsp_add8_cin_tb_pkg;

    localparam int          OP_W      = 18;
    localparam int          RES_W     = 48;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic signed [OP_W-1:0] OP_MAX = 18'h1FFFF;
    localparam logic signed [OP_W-1:0] OP_MIN = 18'h20000;

    typedef enum logic [2:0] {
        IDLE,
        SB_CLR,
        DIRECTED,
        RANDOM,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic signed [OP_W-1:0] op0_l;
        logic signed [OP_W-1:0] op1_l;
        logic signed [OP_W-1:0] op2_h;
        logic signed [OP_W-1:0] op3_h;
        logic signed [OP_W-1:0] op4_l;
        logic signed [OP_W-1:0] op5_l;
        logic signed [OP_W-1:0] op6_h;
        logic signed [OP_W-1:0] op7_h;
        logic                   op2_cin;
        logic                   op3_cin;
        logic                   op6_cin;
        logic                   op7_cin;
    } vec_t;

    localparam vec_t DIR_VECS [4] = '{
        '0,
        '{OP_MAX, OP_MAX, OP_MAX, OP_MAX, OP_MAX, OP_MAX, OP_MAX, OP_MAX, 1'b1, 1'b1, 1'b1, 1'b1},
        '{OP_MIN, OP_MIN, OP_MIN, OP_MIN, OP_MIN, OP_MIN, OP_MIN, OP_MIN, 1'b0, 1'b0, 1'b0, 1'b0},
        '{OP_MAX, OP_MIN, OP_MAX, OP_MIN, OP_MAX, OP_MIN, OP_MAX, OP_MIN, 1'b1, 1'b0, 1'b1, 1'b0}
    };

    function automatic logic [RES_W-1:0] sext(input logic [OP_W-1:0] x);
        return {{(RES_W-OP_W){x[OP_W-1]}}, x};
    endfunction

    function automatic logic [RES_W-1:0] zext1(input logic b);
        return {{(RES_W-1){1'b0}}, b};
    endfunction

    function automatic logic signed [RES_W-1:0] golden_sum(input vec_t v);
        logic [RES_W-1:0] s;
        s = sext(v.op0_l) + sext(v.op1_l) + sext(v.op2_h) + sext(v.op3_h)
          + sext(v.op4_l) + sext(v.op5_l) + sext(v.op6_h) + sext(v.op7_h);
        s = s + zext1(v.op2_cin) + zext1(v.op3_cin) + zext1(v.op6_cin) + zext1(v.op7_cin);
        return s;
    endfunction

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Operand pairs come from four successive steps looked ahead of the current state
    function automatic vec_t gen_vector(input logic [31:0] lfsr);
        logic [31:0] s1, s2, s3, s4;
        vec_t        v;
        s1 = lfsr_step(lfsr);
        s2 = lfsr_step(s1);
        s3 = lfsr_step(s2);
        s4 = lfsr_step(s3);
        v.op0_l   = s1[17:0];
        v.op1_l   = s1[31:14];
        v.op2_h   = s2[17:0];
        v.op3_h   = s2[31:14];
        v.op4_l   = s3[17:0];
        v.op5_l   = s3[31:14];
        v.op6_h   = s4[17:0];
        v.op7_h   = s4[31:14];
        v.op2_cin = s4[0];
        v.op3_cin = s4[1];
        v.op6_cin = s4[2];
        v.op7_cin = s4[3];
        return v;
    endfunction

endpackage

// File: rtl/dsp_add8_cin_stim_lfsr32_gen.sv
// rtl/dsp_add8_cin_stim_lfsr32_gen.sv - 32-bit Galois LFSR advancing two steps per enabled cycle
module lfsr32_gen
    import dsp_add8_cin_tb_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        i_advance,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state <= SEED;
        end else if (i_advance) begin
            r_state <= lfsr_step(lfsr_step(r_state));
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/dsp_add8_cin_stim.sv
// rtl/dsp_add8_cin_stim.sv - stimulus sequencer and delayed golden reference for the 8-input adder
module dsp_add8_cin_stim
    import dsp_add8_cin_tb_pkg::*;
#(
    parameter int          DUV_LATENCY = 4,
    parameter int          NUM_RANDOM  = 1024,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    start,
    output logic signed [OP_W-1:0]  op0_l,
    output logic signed [OP_W-1:0]  op1_l,
    output logic signed [OP_W-1:0]  op2_h,
    output logic signed [OP_W-1:0]  op3_h,
    output logic signed [OP_W-1:0]  op4_l,
    output logic signed [OP_W-1:0]  op5_l,
    output logic signed [OP_W-1:0]  op6_h,
    output logic signed [OP_W-1:0]  op7_h,
    output logic                    op2_cin,
    output logic                    op3_cin,
    output logic                    op6_cin,
    output logic                    op7_cin,
    output logic                    op_valid,
    output logic signed [OP_W-1:0]  op0_l_ref,
    output logic signed [OP_W-1:0]  op1_l_ref,
    output logic signed [OP_W-1:0]  op2_h_ref,
    output logic signed [OP_W-1:0]  op3_h_ref,
    output logic signed [OP_W-1:0]  op4_l_ref,
    output logic signed [OP_W-1:0]  op5_l_ref,
    output logic signed [OP_W-1:0]  op6_h_ref,
    output logic signed [OP_W-1:0]  op7_h_ref,
    output logic                    op2_cin_ref,
    output logic                    op3_cin_ref,
    output logic                    op6_cin_ref,
    output logic                    op7_cin_ref,
    output logic signed [RES_W-1:0] result_ref,
    output logic                    scoreboard_en,
    output logic                    scoreboard_reset,
    output logic                    done
);

    if (DUV_LATENCY < 1 || DUV_LATENCY > 16 || NUM_RANDOM < 1 || NUM_RANDOM > 65535
        || LFSR_SEED == 32'd0) begin : g_param_check
        $error("dsp_add8_cin_stim: illegal parameter set");
    end

    state_t                  r_state;
    state_t                  w_next;
    logic [15:0]             r_cnt;
    logic                    w_cnt_run;
    logic [31:0]             w_lfsr;
    vec_t                    w_vec;
    logic signed [RES_W-1:0] w_sum;

    vec_t                    r_dl_vec   [DUV_LATENCY];
    logic signed [RES_W-1:0] r_dl_sum   [DUV_LATENCY];
    logic                    r_dl_valid [DUV_LATENCY];

    lfsr32_gen #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .aresetn   (aresetn),
        .i_advance (r_state == RANDOM),
        .o_state   (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_run ? r_cnt + 16'd1 : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = SB_CLR;
            SB_CLR:     w_next = DIRECTED;
            DIRECTED:   if (r_cnt == 16'd3) w_next = RANDOM;
            RANDOM:     if (r_cnt == 16'(NUM_RANDOM - 1)) w_next = DRAIN;
            DRAIN:      if (r_cnt == 16'(DUV_LATENCY - 1)) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_run        = (w_next == r_state) && (r_state != IDLE) && (r_state != DONE);
        op_valid         = (r_state == DIRECTED) || (r_state == RANDOM);
        scoreboard_reset = (r_state == SB_CLR);
        done             = (r_state == DONE);
        w_vec            = '0;
        if (r_state == DIRECTED) begin
            w_vec = DIR_VECS[r_cnt[1:0]];
        end else if (r_state == RANDOM) begin
            w_vec = gen_vector(w_lfsr);
        end
    end

    // Idle cycles present an all-zero vector, so zeros shift down the line with no extra muxing
    assign w_sum = golden_sum(w_vec);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            for (int i = 0; i < DUV_LATENCY; i++) begin
                r_dl_vec[i]   <= '0;
                r_dl_sum[i]   <= '0;
                r_dl_valid[i] <= 1'b0;
            end
        end else begin
            r_dl_vec[0]   <= w_vec;
            r_dl_sum[0]   <= w_sum;
            r_dl_valid[0] <= op_valid;
            for (int i = 1; i < DUV_LATENCY; i++) begin
                r_dl_vec[i]   <= r_dl_vec[i-1];
                r_dl_sum[i]   <= r_dl_sum[i-1];
                r_dl_valid[i] <= r_dl_valid[i-1];
            end
        end
    end

    assign op0_l   = w_vec.op0_l;
    assign op1_l   = w_vec.op1_l;
    assign op2_h   = w_vec.op2_h;
    assign op3_h   = w_vec.op3_h;
    assign op4_l   = w_vec.op4_l;
    assign op5_l   = w_vec.op5_l;
    assign op6_h   = w_vec.op6_h;
    assign op7_h   = w_vec.op7_h;
    assign op2_cin = w_vec.op2_cin;
    assign op3_cin = w_vec.op3_cin;
    assign op6_cin = w_vec.op6_cin;
    assign op7_cin = w_vec.op7_cin;

    assign op0_l_ref     = r_dl_vec[DUV_LATENCY-1].op0_l;
    assign op1_l_ref     = r_dl_vec[DUV_LATENCY-1].op1_l;
    assign op2_h_ref     = r_dl_vec[DUV_LATENCY-1].op2_h;
    assign op3_h_ref     = r_dl_vec[DUV_LATENCY-1].op3_h;
    assign op4_l_ref     = r_dl_vec[DUV_LATENCY-1].op4_l;
    assign op5_l_ref     = r_dl_vec[DUV_LATENCY-1].op5_l;
    assign op6_h_ref     = r_dl_vec[DUV_LATENCY-1].op6_h;
    assign op7_h_ref     = r_dl_vec[DUV_LATENCY-1].op7_h;
    assign op2_cin_ref   = r_dl_vec[DUV_LATENCY-1].op2_cin;
    assign op3_cin_ref   = r_dl_vec[DUV_LATENCY-1].op3_cin;
    assign op6_cin_ref   = r_dl_vec[DUV_LATENCY-1].op6_cin;
    assign op7_cin_ref   = r_dl_vec[DUV_LATENCY-1].op7_cin;
    assign result_ref    = r_dl_sum[DUV_LATENCY-1];
    assign scoreboard_en = r_dl_valid[DUV_LATENCY-1];

endmodule

// File: tb/tb_dsp_add8_cin_stim.sv
// tb/tb_dsp_add8_cin_stim.sv - randomized self-checking bench with ideal-DUV scoreboard model
module tb_dsp_add8_cin_stim;
    import dsp_add8_cin_tb_pkg::*;

    localparam int          LAT  = 4;
    localparam int          NR   = 1024;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic start = 1'b0;
    logic signed [17:0] op0_l, op1_l, op2_h, op3_h, op4_l, op5_l, op6_h, op7_h;
    logic signed [17:0] op0_l_ref, op1_l_ref, op2_h_ref, op3_h_ref;
    logic signed [17:0] op4_l_ref, op5_l_ref, op6_h_ref, op7_h_ref;
    logic op2_cin, op3_cin, op6_cin, op7_cin, op_valid;
    logic op2_cin_ref, op3_cin_ref, op6_cin_ref, op7_cin_ref;
    logic signed [47:0] result_ref;
    logic scoreboard_en, scoreboard_reset, done;

    dsp_add8_cin_stim #(.DUV_LATENCY(LAT), .NUM_RANDOM(NR), .LFSR_SEED(SEED)) dut (
        .clk(clk), .aresetn(aresetn), .start(start),
        .op0_l(op0_l), .op1_l(op1_l), .op2_h(op2_h), .op3_h(op3_h),
        .op4_l(op4_l), .op5_l(op5_l), .op6_h(op6_h), .op7_h(op7_h),
        .op2_cin(op2_cin), .op3_cin(op3_cin), .op6_cin(op6_cin), .op7_cin(op7_cin),
        .op_valid(op_valid),
        .op0_l_ref(op0_l_ref), .op1_l_ref(op1_l_ref), .op2_h_ref(op2_h_ref), .op3_h_ref(op3_h_ref),
        .op4_l_ref(op4_l_ref), .op5_l_ref(op5_l_ref), .op6_h_ref(op6_h_ref), .op7_h_ref(op7_h_ref),
        .op2_cin_ref(op2_cin_ref), .op3_cin_ref(op3_cin_ref),
        .op6_cin_ref(op6_cin_ref), .op7_cin_ref(op7_cin_ref),
        .result_ref(result_ref), .scoreboard_en(scoreboard_en),
        .scoreboard_reset(scoreboard_reset), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        longint     op[8];
        logic [3:0] cin;
        longint     sum;
        int         cyc;
        int         idx;
    } exp_t;

    exp_t        q[$];
    longint      dir_sum[4] = '{0, 1048572, -1048576, -2};
    logic [31:0] m_lfsr = SEED;
    int          start_cyc = 0;
    int          n_issue = 0, n_sben = 0, n_sr = 0;
    int          last_valid_cyc = 0, last_sben_cyc = 0, done_cyc = 0;
    logic        done_q = 1'b0;

    function automatic logic [31:0] model_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic exp_t make_expect(input int idx, input logic [31:0] lfsr);
        exp_t e;
        vec_t v;
        e.idx = idx;
        if (idx < 4) begin
            for (int i = 0; i < 8; i++) begin
                case (idx)
                    0:       e.op[i] = 0;
                    1:       e.op[i] = 131071;
                    2:       e.op[i] = -131072;
                    default: e.op[i] = (i % 2 == 0) ? 131071 : -131072;
                endcase
            end
            e.cin = (idx == 1) ? 4'b1111 : (idx == 3) ? 4'b0101 : 4'b0000;
        end else begin
            v = gen_vector(lfsr);
            e.op = '{v.op0_l, v.op1_l, v.op2_h, v.op3_h, v.op4_l, v.op5_l, v.op6_h, v.op7_h};
            e.cin = {v.op7_cin, v.op6_cin, v.op3_cin, v.op2_cin};
        end
        e.sum = 0;
        for (int i = 0; i < 8; i++) e.sum += e.op[i];
        for (int j = 0; j < 4; j++) e.sum += longint'(e.cin[j]);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t   e;
        longint obs[8];
        if (!aresetn) begin
            q.delete();
            m_lfsr = SEED;
            done_q = 1'b0;
        end else begin
            if (scoreboard_reset) begin
                n_sr++;
                n_issue = 0;
                n_sben  = 0;
                check("sb_reset_cyc", cyc, start_cyc + 1);
            end
            if (op_valid) begin
                if (n_issue == 0) check("first_valid_cyc", cyc, start_cyc + 2);
                e = make_expect(n_issue, m_lfsr);
                if (n_issue >= 4) m_lfsr = model_step(model_step(m_lfsr));
                e.cyc = cyc;
                obs = '{op0_l, op1_l, op2_h, op3_h, op4_l, op5_l, op6_h, op7_h};
                for (int i = 0; i < 8; i++) check($sformatf("op%0d_issue", i), obs[i], e.op[i]);
                check("cin_issue", {op7_cin, op6_cin, op3_cin, op2_cin}, e.cin);
                q.push_back(e);
                n_issue++;
                last_valid_cyc = cyc;
            end
            if (scoreboard_en) begin
                if (n_sben == 0) check("first_sben_cyc", cyc, start_cyc + 2 + LAT);
                n_sben++;
                last_sben_cyc = cyc;
                if (q.size() == 0) begin
                    check("sben_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("latency", cyc - e.cyc, LAT);
                    obs = '{op0_l_ref, op1_l_ref, op2_h_ref, op3_h_ref,
                            op4_l_ref, op5_l_ref, op6_h_ref, op7_h_ref};
                    for (int i = 0; i < 8; i++) check($sformatf("op%0d_ref", i), obs[i], e.op[i]);
                    check("cin_ref", {op7_cin_ref, op6_cin_ref, op3_cin_ref, op2_cin_ref}, e.cin);
                    check("result_ref", result_ref, e.sum);
                    if (e.idx < 4) check($sformatf("D%0d_sum", e.idx), result_ref, dir_sum[e.idx]);
                end
            end
            if (done && !done_q) done_cyc = cyc;
            done_q = done;
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_op_valid"}, op_valid, 0);
        check({tag, "_sben"}, scoreboard_en, 0);
        check({tag, "_sbrst"}, scoreboard_reset, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result_ref"}, result_ref, 0);
        check({tag, "_op0"}, op0_l, 0);
        check({tag, "_op7_ref"}, op7_h_ref, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_to_done(input bit poke_mid, input int exp_sr);
        int k;
        pulse_start();
        if (poke_mid) begin
            repeat (100) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        k = 0;
        while (!done && k < NR + 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_reached", done, 1);
        @(negedge clk); #1;
        check("sben_count", n_sben, NR + 4);
        check("sb_reset_pulses", n_sr, exp_sr);
        check("queue_empty", q.size(), 0);
        check("sben_fall", last_sben_cyc, last_valid_cyc + LAT);
        check("done_rise", done_cyc, last_valid_cyc + LAT + 1);
    endtask

    initial begin
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_quiet("reset");
        aresetn = 1'b1;

        run_to_done(1'b1, 1);
        run_to_done(1'b0, 2);

        pulse_start();
        repeat (200) @(posedge clk);
        #1 aresetn = 1'b0;
        @(posedge clk); #1;
        check_quiet("midrun_reset");
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_quiet("after_reset");

        run_to_done(1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
